data_mem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the single-port data_memory.
- Port 0 is the CPU load/store stage. Port 1 is the debug/loader port.
- Grants one access at a time with round-robin fairness and drives the data_memory address, store_data, memRead and memWrite.
- Returns load data and a one-cycle acknowledge to the granted requester.

---
 rtl/data_mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_data_mem_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
//   Two-port round-robin arbiter and access sequencer for a single-port data
//   memory with combinational read and posedge write.
//   Port 0 serves the CPU load/store stage and port 1 the debug/loader port.
//   Each access runs IDLE -> ACCESS -> ACK, so at most one access completes
//   every 3 cycles.
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   reqN/weN/addrN/wdataN  requester N: request, 1=write, address, store data
//   ackN                one-cycle completion pulse to requester N
//   rdataN              last load data for requester N (held between reads)
//   mem_addr/mem_wdata  memory address / store data (held when not accessing)
//   mem_rdata           memory load data (combinational)
//   mem_read/mem_write  memory strobes, high only in ACCESS
//   busy                high while an access is in ACCESS or ACK
// ---------------------------------------------------------------------------
module data_mem_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_gnt;         // id of the port owning the current access
    logic                r_last_grant;  // id of the last completed access
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                w_any_req;
    logic                w_pick;

    assign w_any_req = req0 | req1;
    // Port 1 wins when it is alone, or on a tie when port 0 went last.
    assign w_pick    = req1 & (~req0 | ~r_last_grant);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and decoded strobes
    always_comb begin
        w_state_next = r_state;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        ack0         = 1'b0;
        ack1         = 1'b0;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                busy         = 1'b1;
                mem_write    = r_we;
                mem_read     = ~r_we;
                w_state_next = S_ACK;
            end
            S_ACK: begin
                busy         = 1'b1;
                ack0         = ~r_gnt;
                ack1         = r_gnt;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Grant latch: the winner's operation is frozen at the grant edge so later
    // input changes cannot disturb the access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt        <= 1'b0;
            r_last_grant <= 1'b1;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else begin
            if (r_state == S_IDLE && w_any_req) begin
                r_gnt   <= w_pick;
                r_we    <= w_pick ? we1    : we0;
                r_addr  <= w_pick ? addr1  : addr0;
                r_wdata <= w_pick ? wdata1 : wdata0;
            end
            if (r_state == S_ACK) begin
                r_last_grant <= r_gnt;
            end
        end
    end

    // Per-port load data holding registers, updated only by that port's reads.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
        logic [DATA_W-1:0] r_rdata;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rdata <= '0;
            end else if (r_state == S_ACCESS && !r_we && r_gnt == 1'(gi)) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    assign rdata0    = g_rdata[0].r_rdata;
    assign rdata1    = g_rdata[1].r_rdata;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_mem_arbiter
//   Self-checking bench for data_mem_arbiter. A small memory model sits on the
//   memory side. A transaction-level reference predicts every cycle's outputs:
//   a grant may happen only 3+ cycles after the previous one, the winner follows
//   the round-robin rule, and memory effects land one cycle after the grant.
// ---------------------------------------------------------------------------
module tb_data_mem_arbiter;
    localparam int DW = 16;
    localparam int AW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_read, mem_write, busy;

    data_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .busy(busy)
    );

    // Memory attached to the arbiter (256 words are enough for the stimulus).
    logic [DW-1:0] mem [0:255] = '{default: 16'h5555};
    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge clk) if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state
    logic [DW-1:0] ref_mem [0:255];
    int            m_g;                // cycle of the most recent grant
    logic          m_id, m_we, m_last;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] exp_rdata [2];

    // Requester bookkeeping
    logic pend0, pend1, seen0, seen1;
    int   auto0, auto1;
    int   ack_port_q[$];
    int   ack_cyc_q[$];
    int   low_run, max_low;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_g = -100; m_last = 1'b1; m_id = 1'b0; m_we = 1'b0;
        m_addr = '0; m_wdata = '0;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
    endtask

    // Called right after each posedge with the inputs the DUT just sampled.
    task automatic model_step();
        if (cyc == m_g + 1) begin
            if (m_we) ref_mem[m_addr[7:0]] = m_wdata;
            else      exp_rdata[m_id] = ref_mem[m_addr[7:0]];
        end
        if (cyc >= m_g + 3 && (req0 || req1)) begin
            m_id    = (req0 && req1) ? ~m_last : req1;
            m_we    = m_id ? we1    : we0;
            m_addr  = m_id ? addr1  : addr0;
            m_wdata = m_id ? wdata1 : wdata0;
            m_last  = m_id;
            m_g     = cyc;
        end
    endtask

    task automatic check_cycle();
        logic acc, ak;
        acc = (cyc == m_g);
        ak  = (cyc == m_g + 1);
        chk("busy",      busy,      acc || ak);
        chk("mem_write", mem_write, acc && m_we);
        chk("mem_read",  mem_read,  acc && !m_we);
        chk("mem_addr",  mem_addr,  m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("ack0",      ack0,      ak && !m_id);
        chk("ack1",      ack1,      ak && m_id);
        chk("rdata0",    rdata0,    exp_rdata[0]);
        chk("rdata1",    rdata1,    exp_rdata[1]);
        if (!busy) low_run++; else low_run = 0;
        if (low_run > max_low) max_low = low_run;
    endtask

    task automatic issue(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; pend0 = 1'b1; end
        else        begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; pend1 = 1'b1; end
    endtask

    task automatic issue_rand(input int p);
        issue(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
    endtask

    // One clock: model at the edge, requester reaction #1 later, checks at negedge.
    task automatic cycle();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        if (seen0) begin
            req0 = 1'b0; pend0 = 1'b0; seen0 = 1'b0;
            addr0 = AW'($urandom); wdata0 = DW'($urandom);
            if (auto0 > 0) begin auto0--; issue_rand(0); end
        end
        if (seen1) begin
            req1 = 1'b0; pend1 = 1'b0; seen1 = 1'b0;
            addr1 = AW'($urandom); wdata1 = DW'($urandom);
            if (auto1 > 0) begin auto1--; issue_rand(1); end
        end
        @(negedge clk);
        check_cycle();
        if (ack0 && pend0) begin seen0 = 1'b1; ack_port_q.push_back(0); ack_cyc_q.push_back(cyc); end
        if (ack1 && pend1) begin seen1 = 1'b1; ack_port_q.push_back(1); ack_cyc_q.push_back(cyc); end
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((pend0 || pend1 || seen0 || seen1) && n < limit) begin
            cycle();
            n++;
        end
        chk("drain_timeout", {30'd0, pend0, pend1}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        pend0 = 1'b0; pend1 = 1'b0; seen0 = 1'b0; seen1 = 1'b0;
        auto0 = 0; auto1 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        we0 = 1'b0; we1 = 1'b0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        low_run = 0; max_low = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h5555;
        do_reset();

        // Port 0 write, then port 1 read of the same word
        issue(0, 1'b1, 16'd1, 16'h000F);
        drain(10);
        chk("mem1_written", mem[1], 16'h000F);
        $display("txn: port0 write addr=1 data=000F");
        issue(1, 1'b0, 16'd1, 16'h0000);
        drain(10);
        chk("rdata1_read", rdata1, 16'h000F);
        repeat (10) cycle();
        chk("rdata1_held", rdata1, 16'h000F);
        $display("txn: port1 read addr=1 rdata1=%h", rdata1);

        // Tie straight out of reset: port 0 first, acks 3 cycles apart
        do_reset();
        ack_port_q.delete(); ack_cyc_q.delete();
        issue(0, 1'b0, 16'd1, 16'h0000);
        issue(1, 1'b0, 16'd2, 16'h0000);
        drain(12);
        chk("tie_count",  ack_port_q.size(), 2);
        chk("tie_first",  ack_port_q[0], 0);
        chk("tie_second", ack_port_q[1], 1);
        chk("tie_spacing", ack_cyc_q[1] - ack_cyc_q[0], 3);
        $display("txn: tie acks ports %0d,%0d", ack_port_q[0], ack_port_q[1]);

        // Continuous contention: 6 accesses alternating 0,1,0,1,0,1
        ack_port_q.delete(); ack_cyc_q.delete();
        low_run = 0; max_low = 0;
        auto0 = 2; auto1 = 2;
        issue_rand(0);
        issue_rand(1);
        drain(40);
        chk("contend_count", ack_port_q.size(), 6);
        for (int i = 0; i < 6; i++) chk("contend_order", ack_port_q[i], i % 2);
        chk("busy_gap_le1", max_low <= 1, 1'b1);
        $display("txn: contention 6 accesses, max idle gap %0d", max_low);

        // Late arrival: port 1 asks while port 0 is in ACCESS
        ack_port_q.delete(); ack_cyc_q.delete();
        issue(0, 1'b1, 16'd3, 16'h1234);
        cycle();
        issue(1, 1'b0, 16'd3, 16'h0000);
        drain(12);
        chk("late_order0", ack_port_q[0], 0);
        chk("late_order1", ack_port_q[1], 1);
        chk("late_rdata1", rdata1, 16'h1234);
        $display("txn: late arrival port1 read addr=3 rdata1=%h", rdata1);

        // Reset in the middle of a write to addr 5
        issue(0, 1'b1, 16'd5, 16'hAAAA);
        cycle();
        chk("midwr_strobe", mem_write, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_cycle();
        do_reset();
        repeat (2) cycle();
        chk("mem5_kept", mem[5], 16'h5555);
        issue(1, 1'b0, 16'd5, 16'h0000);
        drain(10);
        chk("mem5_readback", rdata1, 16'h5555);
        $display("txn: reset mid-write, mem[5]=%h", mem[5]);

        // Random traffic from both ports
        for (int c = 0; c < 200; c++) begin
            if (!pend0 && !seen0 && $urandom_range(0, 2) == 0) issue_rand(0);
            if (!pend1 && !seen1 && $urandom_range(0, 2) == 0) issue_rand(1);
            cycle();
        end
        drain(20);
        $display("txn: random phase done, %0d acks total in log", ack_port_q.size());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
